bus_generator_arbiter: RTL and testbench
========================================

Name: bus_generator_arbiter

Overview:
- Shared-bus model with a round-robin arbiter for `drvrs` attached agents (drivers).
- Each driver exposes a first-word-fall-through input FIFO to the bus: `pndng`, `pop`, `D_pop`.
- The bus grants one pending driver at a time, pops its head packet and delivers it to the destination driver via `push`/`D_push`.
- It is the DUT between the driver/agent layer and the checker/scoreboard.

Parameters:
- drvrs, 4, number of attached drivers (2..255).
- pckg_sz, 16, packet width in bits (must be >= 9).
- broadcast, 8'hFF, destination ID meaning "all drivers except source".

Ports:
- clk  input  1  bus clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pndng  input  drvrs  bit i high = driver i FIFO holds a packet; D_pop slice i is valid.
- D_pop  input  drvrs*pckg_sz  head packet of driver i at bits [i*pckg_sz +: pckg_sz].
- pop  output  drvrs  one-cycle pulse, bit i removes the head of driver i FIFO.
- push  output  drvrs  one-cycle pulse, bit i writes D_push slice i into driver i.
- D_push  output  drvrs*pckg_sz  delivered packet; every slice carries the same value.

Behaviour:
- Packet format: destination ID = packet[pckg_sz-1 -: 8]; the remaining low bits are payload, passed through unmodified.
- Reset (reset=0, asynchronous):
  - pop=0, push=0, D_push=0, state=IDLE, latched packet=0.
  - Last-grant pointer = drvrs-1, so driver 0 has first priority.
- State machine: IDLE -> POP -> PUSH -> IDLE.
- IDLE:
  - If any pndng bit is set, select the first set bit searching last_grant+1, last_grant+2, ... modulo drvrs.
  - Register it as grant and last_grant; go to POP.
  - Otherwise stay in IDLE.
- POP (one cycle):
  - pop[grant]=1 only if pndng[grant] is still 1.
  - At the clock edge, latch D_pop slice `grant` and go to PUSH.
  - If pndng[grant]=0 in this cycle: no pop, no latch, return to IDLE.
- PUSH (one cycle):
  - D_push = latched packet on all slices.
  - dest < drvrs: push[dest]=1. dest == source is allowed and delivers back to the source.
  - dest == broadcast: push[j]=1 for all j != grant.
  - Any other dest (out of range): packet dropped, push=0 (pop already consumed it).
  - Return to IDLE.
- Throughput: one packet per 3 cycles. Pop-to-push latency is 1 cycle.
- pop and push are never high in the same cycle.
- At most one pop bit is high at any time.
- D_push holds its last value outside PUSH; receivers qualify it with push only.
- Fairness: a continuously pending driver is granted at least once every drvrs transactions.
- Reset asserted mid-transaction aborts immediately. A packet popped but not yet pushed is lost.
- Arbitration samples only in IDLE; pndng changes during POP/PUSH affect the next arbitration only.

Test Plan:
1. Reset then idle: reset=0 for 5 cycles, then 1, pndng=0 -> pop=0, push=0, D_push=0 for 20 cycles.
2. Single transfer: pndng=4'b0001, D_pop[0]=16'h02AB -> pop=4'b0001 for one cycle, next cycle push=4'b0100 with D_push slices=16'h02AB, then idle.
3. Round-robin: all four drivers pending continuously, each packet addressed to (src+1)%4 -> grant order 0,1,2,3,0..., each pop pulse 3 cycles apart, 20 packets delivered in order per source.
4. Broadcast: driver 2 pops 16'hFF5A -> push=4'b1011, D_push=16'hFF5A.
5. Invalid destination: driver 1 pops 16'h0711 with drvrs=4 -> pop[1] pulses, push stays 0, next arbitration proceeds normally.
6. Async reset mid-transfer: assert reset=0 during POP -> pop/push drop to 0 immediately without waiting for clk; after release, driver 0 is granted first.

Source files
------------

// File: rtl/bus_generator_arbiter.sv
// Shared bus: round-robin grant among pending drivers, pop the head packet, then push it to its destination.
// One packet every 3 cycles (IDLE/POP/PUSH). Pop-to-push latency is 1 cycle. Drivers stall only by leaving pndng low.
module bus_generator_arbiter #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [drvrs*pckg_sz-1:0]   D_push
);

  localparam int         IW   = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [7:0] DRV8 = 8'(drvrs);

  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t             state, state_nxt;
  idx_t               grant, grant_nxt, cand;
  logic               found;
  logic [pckg_sz-1:0] head, pkt;
  logic [7:0]         dest;

  // grant also serves as the round-robin pointer: the search starts just after it
  always_comb begin
    grant_nxt = grant;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= drvrs; k++) begin
      cand = idx_t'((int'(grant) + k) % drvrs);
      if (!found && pndng[cand]) begin
        found     = 1'b1;
        grant_nxt = cand;
      end
    end
  end

  always_comb begin
    head = '0;
    for (int j = 0; j < drvrs; j++) begin
      if (grant == idx_t'(j)) head = D_pop[j*pckg_sz +: pckg_sz];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = POP;
      POP:     state_nxt = pndng[grant] ? PUSH : IDLE;
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset points at the last driver so driver 0 wins the first arbitration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant <= idx_t'(drvrs - 1);
      pkt   <= '0;
    end else begin
      if (state == IDLE && found)         grant <= grant_nxt;
      if (state == POP  && pndng[grant])  pkt   <= head;
    end
  end

  always_comb begin
    pop  = '0;
    push = '0;
    dest = pkt[pckg_sz-1 -: 8];
    for (int j = 0; j < drvrs; j++) begin
      pop[j] = (state == POP) && pndng[j] && (grant == idx_t'(j));
      if (state == PUSH) begin
        if (dest == broadcast)  push[j] = (grant != idx_t'(j));
        else if (dest < DRV8)   push[j] = (dest == 8'(j));
      end
    end
  end

  assign D_push = {drvrs{pkt}};

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Scoreboard bench: expected pop/push events are queued with the stimulus; a monitor checks each bus output.
module tb_bus_generator_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  typedef struct packed {
    logic         is_push;
    logic [N-1:0] vec;
    logic [W-1:0] dat;
  } ev_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   pndng, pop, push;
  logic [N*W-1:0] D_pop, D_push;

  ev_t          sb[$];
  logic [W-1:0] fifo[N][$];
  bit           taken[N];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           last_pop = -1;
  bit           stream = 1'b0;

  always #5 clk = ~clk;

  bus_generator_arbiter #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_pop(input logic [N-1:0] v);
    ev_t e;
    e.is_push = 1'b0; e.vec = v; e.dat = '0;
    sb.push_back(e);
  endtask

  task automatic expect_push(input logic [N-1:0] v, input logic [W-1:0] d);
    ev_t e;
    e.is_push = 1'b1; e.vec = v; e.dat = d;
    sb.push_back(e);
  endtask

  task automatic load(input int i, input logic [W-1:0] p);
    fifo[i].push_back(p);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int n;
    logic [W-1:0] p;
    pndng = '0;
    D_pop = '0;
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      // Driver FIFO model: head removed one cycle after the pop pulse is seen
      forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++)
          if (taken[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        for (int i = 0; i < N; i++) taken[i] = pop[i] && reset;
        for (int i = 0; i < N; i++) begin
          pndng[i] = fifo[i].size() > 0;
          D_pop[i*W +: W] = pndng[i] ? fifo[i][0] : '0;
        end
      end
      begin : monitor
        ev_t e;
        forever begin
          @(negedge clk);
          if (reset && (pop != '0 || push != '0)) begin
            chk("pop_push_overlap", 64'((pop != '0) && (push != '0)), 64'(0));
            chk("pop_onehot", 64'($countones(pop) > 1), 64'(0));
            if (sb.size() == 0) begin
              chk("unexpected_output", 64'({pop, push}), 64'(0));
            end else begin
              e = sb.pop_front();
              if (!e.is_push) begin
                chk("pop_vec", 64'(pop), 64'(e.vec));
                if (stream && last_pop >= 0) chk("pop_spacing", 64'(cyc - last_pop), 64'(3));
                last_pop = cyc;
              end else begin
                chk("push_vec", 64'(push), 64'(e.vec));
                chk("pop_to_push", 64'(cyc - last_pop), 64'(1));
                for (int j = 0; j < N; j++) chk("d_push_slice", 64'(D_push[j*W +: W]), 64'(e.dat));
              end
            end
          end
        end
      end
    join_none

    // Reset then idle
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_pop", 64'(pop), 64'(0));
    chk("rst_push", 64'(push), 64'(0));
    chk("rst_d_push", 64'(D_push), 64'(0));
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_pop", 64'(pop), 64'(0));
      chk("idle_push", 64'(push), 64'(0));
      chk("idle_d_push", 64'(D_push), 64'(0));
    end

    // Single transfer 0 -> 2
    @(posedge clk); #2;
    load(0, 16'h02AB);
    expect_pop(4'b0001);
    expect_push(4'b0100, 16'h02AB);
    wait_drain(30);
    @(negedge clk);
    chk("d_push_hold", 64'(D_push[W-1:0]), 64'(16'h02AB));
    chk("push_low_after", 64'(push), 64'(0));

    // Broadcast from driver 2
    load(2, 16'hFF5A);
    expect_pop(4'b0100);
    expect_push(4'b1011, 16'hFF5A);
    wait_drain(30);

    // Out-of-range destination from driver 1 is dropped; driver 2 follows normally
    load(1, 16'h0711);
    load(2, 16'h0122);
    expect_pop(4'b0010);
    expect_pop(4'b0100);
    expect_push(4'b0010, 16'h0122);
    wait_drain(40);

    // Async reset during POP; driver 0 must win first afterwards
    load(2, 16'h0333);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (pop == '0 && n < 20);
    chk("t6_pop_seen", 64'(pop), 64'(4'b0100));
    reset = 1'b0;
    #1;
    chk("t6_async_pop", 64'(pop), 64'(0));
    chk("t6_async_push", 64'(push), 64'(0));
    chk("t6_async_d_push", 64'(D_push), 64'(0));
    load(0, 16'h0200);
    load(3, 16'h0100);
    expect_pop(4'b0001);
    expect_push(4'b0100, 16'h0200);
    expect_pop(4'b0100);
    expect_push(4'b1000, 16'h0333);
    expect_pop(4'b1000);
    expect_push(4'b0010, 16'h0100);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_drain(60);

    // Round-robin with all drivers pending, each sending to its neighbour
    stream = 1'b1;
    last_pop = -1;
    for (int k = 0; k < 20; k++) begin
      for (int s = 0; s < N; s++) begin
        p = {8'((s + 1) % N), 8'(s * 32 + k)};
        load(s, p);
        expect_pop(4'(1 << s));
        expect_push(4'(1 << ((s + 1) % N)), p);
      end
    end
    wait_drain(400);
    stream = 1'b0;

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
